if_fetch_unit: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the RV32I pipeline.
- Owns the PC and issues requests to instruction memory/cache over a read/busywait handshake.
- Handles stall from the hazard unit and branch/jump redirect from EX.
- Drives the registered INSTRUCTION, PC and PC+4 consumed by decode and the immediate-extension wiring.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fetch_unit_ifid_reg.sv | 40 ++++
 rtl/if_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_ifid_reg.sv
// Pipeline register between fetch and decode: load enable plus bubble insert.
module ifid_reg
    import if_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [DATA_W-1:0] d_pc,
    input  logic [DATA_W-1:0] d_pc4,
    input  logic              d_valid,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc4,
    output logic              valid
);

    // A bubble replaces only the instruction and valid; the PCs keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= d_instr;
            pc    <= d_pc;
            pc4   <= d_pc4;
            valid <= d_valid;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch: PC, imem handshake FSM, one-entry skid buffer and IF/ID register.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        VALID
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] old_addr, old_addr_n;
    logic [31:0] buf_instr, buf_pc;
    logic        buf_valid, buf_valid_n, buf_load;
    logic        boot;
    logic        imem_read, accept;
    logic        ifid_load, ifid_flush, ifid_valid_d;
    logic [31:0] ifid_instr_d, ifid_pc_d;
    logic [31:0] target;

    assign target       = BRANCH_TARGET & 32'hFFFF_FFFC;
    // No request in the first cycle after reset, so memory sees a clean idle cycle.
    assign imem_read    = !boot && (state != ST_HOLD);
    assign accept       = imem_read && !IMEM_BUSYWAIT;
    assign IMEM_READ    = imem_read;
    assign IMEM_ADDRESS = (state == ST_DRAIN) ? old_addr : pc;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        old_addr_n   = old_addr;
        buf_valid_n  = buf_valid;
        buf_load     = 1'b0;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr_d = IMEM_READDATA;
        ifid_pc_d    = pc;
        ifid_valid_d = 1'b1;
        if (BRANCH_TAKEN) begin
            ifid_flush  = 1'b1;
            pc_n        = target;
            buf_valid_n = 1'b0;
            case (state)
                ST_FETCH: begin
                    // An outstanding request must complete before the target can be issued.
                    if (imem_read && IMEM_BUSYWAIT) begin
                        old_addr_n = pc;
                        state_n    = ST_DRAIN;
                    end
                end
                ST_HOLD:  state_n = ST_FETCH;
                ST_DRAIN: if (accept) state_n = ST_FETCH;
                default:  state_n = ST_FETCH;
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (accept) begin
                        if (!STALL) begin
                            ifid_load = 1'b1;
                            pc_n      = pc_inc(pc);
                        end else begin
                            buf_load    = 1'b1;
                            buf_valid_n = 1'b1;
                            state_n     = ST_HOLD;
                        end
                    end else if (!STALL) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        ifid_load    = 1'b1;
                        ifid_instr_d = buf_instr;
                        ifid_pc_d    = buf_pc;
                        ifid_valid_d = buf_valid;
                        pc_n         = pc_inc(buf_pc);
                        buf_valid_n  = 1'b0;
                        state_n      = ST_FETCH;
                    end
                end
                ST_DRAIN: if (accept) state_n = ST_FETCH;
                default:  state_n = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC_ALIGNED;
            boot      <= 1'b1;
            buf_valid <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            boot      <= 1'b0;
            buf_valid <= buf_valid_n;
        end
    end

    // Datapath holding registers; their contents are qualified by state/buf_valid.
    always_ff @(posedge CLK) begin
        old_addr <= old_addr_n;
        if (buf_load) begin
            buf_instr <= IMEM_READDATA;
            buf_pc    <= pc;
        end
    end

    ifid_reg #(
        .DATA_W    (32),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk     (CLK),
        .rst     (RESET),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .d_instr (ifid_instr_d),
        .d_pc    (ifid_pc_d),
        .d_pc4   (pc_inc(ifid_pc_d)),
        .d_valid (ifid_valid_d),
        .instr   (INSTRUCTION),
        .pc      (PC_OUT),
        .pc4     (PC_PLUS4),
        .valid   (VALID)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue of expected fetch PCs, monitor checks each new IF/ID instruction.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET, STALL, BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_ADDRESS, IMEM_READDATA, INSTRUCTION, PC_OUT, PC_PLUS4;
    logic        IMEM_READ, IMEM_BUSYWAIT, VALID;

    logic [31:0] addr2, instr2, pc_out2, pc_plus4_2;
    logic        read2, valid2;

    int          total = 0;
    int          bad = 0;
    int          lat;
    int          cnt;
    logic        stall_q, rst_q;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0033;
    endfunction

    // Memory model: each access waits `lat` cycles with BUSYWAIT high.
    assign IMEM_BUSYWAIT = IMEM_READ && (cnt < lat);
    assign IMEM_READDATA = word(IMEM_ADDRESS);
    always @(posedge CLK) begin
        if (RESET) cnt <= 0;
        else if (IMEM_READ) cnt <= IMEM_BUSYWAIT ? cnt + 1 : 0;
    end

    if_fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_ADDRESS  (IMEM_ADDRESS),
        .IMEM_READ     (IMEM_READ),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .INSTRUCTION   (INSTRUCTION),
        .PC_OUT        (PC_OUT),
        .PC_PLUS4      (PC_PLUS4),
        .VALID         (VALID)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_ADDRESS  (addr2),
        .IMEM_READ     (read2),
        .IMEM_READDATA (word(addr2)),
        .IMEM_BUSYWAIT (1'b0),
        .INSTRUCTION   (instr2),
        .PC_OUT        (pc_out2),
        .PC_PLUS4      (pc_plus4_2),
        .VALID         (valid2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    always @(posedge CLK) begin
        stall_q <= STALL;
        rst_q   <= RESET;
    end

    // A valid IF/ID word after a non-stalled edge is a newly delivered instruction.
    always @(negedge CLK) begin
        if (VALID === 1'b1 && stall_q === 1'b0 && rst_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got pc %h expected no instruction", PC_OUT);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", PC_OUT, e);
                chk("sb_instr", INSTRUCTION, word(e));
                chk("sb_pc4", PC_PLUS4, e + 32'd4);
            end
        end
    end

    initial begin
        RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0; lat = 0;

        // zero-wait streaming, plus wrap-around instance
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        do_reset();
        chk("rst_read", IMEM_READ, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_instr", INSTRUCTION, 32'h13);
        chk("rst_pc", PC_OUT, 0);
        chk("rst_pc4", PC_PLUS4, 0);
        chk("rst_addr", IMEM_ADDRESS, 0);
        chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_rst_read", read2, 0);
        step();
        chk("t1_addr0", IMEM_ADDRESS, 32'h0);
        chk("t1_read", IMEM_READ, 1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        step();
        chk("t1_addr4", IMEM_ADDRESS, 32'h4);
        chk("t1_valid", VALID, 1);
        chk("t1_pc0", PC_OUT, 32'h0);
        chk("t1_pc4", PC_PLUS4, 32'h4);
        chk("wrap_addr1", addr2, 32'h0);
        chk("wrap_pc", pc_out2, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_2, 32'h0);
        step();
        chk("t1_addr8", IMEM_ADDRESS, 32'h8);
        chk("t1_pc1", PC_OUT, 32'h4);
        chk("t1_pc1_4", PC_PLUS4, 32'h8);
        chk("wrap_pc1", pc_out2, 32'h0);
        step();
        chk("t1_addrC", IMEM_ADDRESS, 32'hC);
        do_reset();
        chk("t1_sb_empty", exp_q.size(), 0);

        // three wait cycles per access
        lat = 3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t2_addr_hold", IMEM_ADDRESS, 32'h0);
            chk("t2_read", IMEM_READ, 1);
            if (i > 0) begin
                chk("t2_bubble_instr", INSTRUCTION, 32'h13);
                chk("t2_bubble_valid", VALID, 0);
            end
            step();
        end
        chk("t2_valid0", VALID, 1);
        chk("t2_pc0", PC_OUT, 32'h0);
        step();
        chk("t2_bubble2_instr", INSTRUCTION, 32'h13);
        chk("t2_bubble2_valid", VALID, 0);
        chk("t2_bubble2_pc", PC_OUT, 32'h0);
        chk("t2_addr4", IMEM_ADDRESS, 32'h4);
        repeat (3) step();
        chk("t2_valid1", VALID, 1);
        chk("t2_pc1", PC_OUT, 32'h4);
        do_reset();
        chk("t2_sb_empty", exp_q.size(), 0);

        // stall raised in an accept cycle, held four cycles
        lat = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        do_reset();
        repeat (3) step();
        STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_read", IMEM_READ, 0);
            chk("t3_hold_pc", PC_OUT, 32'h4);
            chk("t3_hold_instr", INSTRUCTION, word(32'h4));
            chk("t3_hold_valid", VALID, 1);
        end
        STALL = 1'b0;
        step();
        chk("t3_buf_pc", PC_OUT, 32'h8);
        chk("t3_buf_instr", INSTRUCTION, word(32'h8));
        chk("t3_next_addr", IMEM_ADDRESS, 32'hC);
        chk("t3_next_read", IMEM_READ, 1);
        step();
        chk("t3_pcC", PC_OUT, 32'hC);
        do_reset();
        chk("t3_sb_empty", exp_q.size(), 0);

        // redirect while a slow access to 0x10 is outstanding
        lat = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h100);
        do_reset();
        repeat (5) step();
        lat = 3;
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
        step();
        BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        chk("t4_drain_addr", IMEM_ADDRESS, 32'h10);
        chk("t4_drain_read", IMEM_READ, 1);
        chk("t4_flush_valid", VALID, 0);
        chk("t4_flush_instr", INSTRUCTION, 32'h13);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_drain_hold", IMEM_ADDRESS, 32'h10);
        end
        step();
        chk("t4_target_addr", IMEM_ADDRESS, 32'h100);
        chk("t4_discard_valid", VALID, 0);
        chk("t4_discard_pc", PC_OUT, 32'hC);
        lat = 0;
        step();
        chk("t4_first_valid", VALID, 1);
        chk("t4_first_pc", PC_OUT, 32'h100);
        chk("t4_first_pc4", PC_PLUS4, 32'h104);
        do_reset();
        chk("t4_sb_empty", exp_q.size(), 0);

        // redirect together with stall and accept
        lat = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        do_reset();
        repeat (2) step();
        STALL = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h203;
        step();
        STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        chk("t5_bubble_valid", VALID, 0);
        chk("t5_bubble_instr", INSTRUCTION, 32'h13);
        chk("t5_addr", IMEM_ADDRESS, 32'h200);
        chk("t5_read", IMEM_READ, 1);
        chk("t5_pc_hold", PC_OUT, 32'h0);
        step();
        chk("t5_pc", PC_OUT, 32'h200);
        chk("t5_valid", VALID, 1);
        step();
        chk("t5_pc_next", PC_OUT, 32'h204);
        do_reset();
        chk("t5_sb_empty", exp_q.size(), 0);

        // reset while draining
        lat = 3;
        do_reset();
        step();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
        step();
        BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        chk("t6_drain_addr", IMEM_ADDRESS, 32'h0);
        do_reset();
        chk("t6_rst_read", IMEM_READ, 0);
        chk("t6_rst_valid", VALID, 0);
        chk("t6_rst_addr", IMEM_ADDRESS, 32'h0);
        chk("t6_rst_instr", INSTRUCTION, 32'h13);
        step();
        chk("t6_read", IMEM_READ, 1);
        chk("t6_addr", IMEM_ADDRESS, 32'h0);
        lat = 0;
        do_reset();
        step();
        chk("final_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
